bme280_poller: RTL
==================

# bme280_poller

Autonomous BME280 measurement sequencer that replaces the static register-selector front end of the I2C master. After enable, it issues a configurable init write sequence (soft reset, ctrl_hum, ctrl_meas, config). It then polls a parametrised burst of consecutive data registers at a fixed period and publishes each complete, coherent frame with a valid strobe. It sits between the board top level and `i2c_master` and owns every command field the master consumes.

## Interface
Parameters:
- `SLAVE_ADDRESS`, 7'h76, BME280 7-bit address.
- `N_READ`, 8, bytes per frame (1..16); register i of a frame is `BASE_REG + i`.
- `BASE_REG`, 8'hF7, first data register (press_msb).
- `CTRL_HUM`, 8'h01, value written to 0xF2.
- `CTRL_MEAS`, 8'h27, value written to 0xF4 (osrs x1, normal mode).
- `CONFIG`, 8'h00, value written to 0xF5.
- `RST_WAIT`, 20000, cycles idle after the 0xE0←0xB6 soft reset.
- `POLL_PERIOD`, 1000000, cycles from one frame start to the next (≥ frame duration, else back-to-back).
- `TIMEOUT`, 65535, max cycles waiting for `m_done` per transaction.

Ports:
- `clk` in 1: system clock.
- `rst` in 1: reset, asynchronous, active-low.
- `en` in 1: level; 1 runs the sequencer, 0 returns it to IDLE at the next transaction boundary.
- `m_slave_address` out 7: master slave address.
- `m_read_write` out 1: 1 = read, 0 = write.
- `m_register_address` out 8: register address.
- `m_data` out 8: write data (0 on reads).
- `m_en` out 1: transaction request, held until `m_done`.
- `m_done` in 1: one-cycle completion pulse from the master.
- `m_nack` in 1: valid with `m_done`; 1 = slave NACK.
- `m_rdata` in 8: read byte, valid with `m_done`.
- `frame_data` out 8*N_READ: last complete frame; byte i at [8i+7:8i].
- `frame_valid` out 1: one-cycle pulse when `frame_data` updates.
- `frame_count` out 16: completed frames, wraps 0xFFFF→0.
- `busy` out 1: state ≠ IDLE.
- `err` out 1: sticky error; clears only on entering IDLE.

## Operation
- States: IDLE, RST_WR, RST_DLY, CFG (3 writes, index 0..2), WAIT_PER, RD (index 0..N_READ-1), PUB, ERR.
- IDLE → RST_WR when `en`=1. RST_WR writes 0xB6 to 0xE0. RST_DLY counts `RST_WAIT`. CFG writes F2←CTRL_HUM, F4←CTRL_MEAS, F5←CONFIG in that order (ctrl_hum must precede ctrl_meas).
- After CFG, enter RD immediately; the period counter starts at RD entry of each frame.
- RD issues single-byte reads of `BASE_REG+idx`; each `m_rdata` goes into a shadow buffer, never directly into `frame_data`.
- PUB, one cycle: shadow → `frame_data`, `frame_valid`=1, `frame_count`+1. Then WAIT_PER until the period counter reaches `POLL_PERIOD`-1, then RD with idx=0.
- Transaction handshake: command fields and `m_en` are registered together in the issue cycle. Fields stay stable while `m_en`=1. `m_en` drops in the cycle after `m_done` is sampled. No new request for at least one cycle after the drop.
- Errors: `m_done`&`m_nack`, or the timeout counter reaching `TIMEOUT`, sets `err` and moves to ERR. The shadow buffer is discarded and `frame_data` is unchanged. ERR drives `m_en`=0 and waits for `en`=0 → IDLE.
- `m_done` and timeout expiry in the same cycle: `m_done` wins.
- `en` falling mid-transaction: the current transaction completes (never abort the bus), the partial frame is discarded, then IDLE. `en` falling in RST_DLY or WAIT_PER → IDLE next cycle.
- Re-enable always restarts from RST_WR.
- Address arithmetic is 8-bit, `BASE_REG+idx` wraps mod 256.

## Timing
- Reset values: all command outputs 0, `m_en` 0, `frame_data` 0, `frame_valid` 0, `frame_count` 0, `busy` 0, `err` 0, state IDLE.
- `en` rise → `m_en` high 2 cycles later (IDLE→RST_WR, then issue).
- Last read's `m_done` → `frame_valid` 2 cycles later (PUB).
- `frame_valid` is exactly 1 cycle. `frame_data` is held until the next PUB.

## Structure
- Package `bme280_pkg`: register-address constants (0xD0, 0xE0, 0xF2, 0xF4, 0xF5, 0xF7–0xFE), soft-reset value 0xB6, state enum.
- One sub-module, `i2c_txn_issuer`: owns the `m_en`/`m_done` handshake, command registers, timeout counter, NACK detection. It returns `txn_ok`/`txn_err`/`rdata` to the sequencer FSM.

## Test plan
- Init: `en`=1, master model acks all → writes observed E0←B6, then after `RST_WAIT` cycles F2←01, F4←27, F5←00, in order.
- Frame: model returns 0x10+i for register F7+i, N_READ=8 → `frame_data`=64'h1716151413121110, one `frame_valid`, `frame_count`=1; next frame starts exactly `POLL_PERIOD` cycles after the first RD issue.
- NACK on 3rd read → `err`=1, `frame_data` keeps the previous frame, no `frame_valid`; `en`=0 → IDLE, `err`=0.
- No `m_done` → `err`=1 after `TIMEOUT` cycles. `m_done` arriving on the expiry cycle → no error.
- `en` dropped mid-read → that read completes (`m_en` held until `m_done`), no `frame_valid`, IDLE. `rst` asserted mid-frame → all outputs 0 asynchronously.
- `frame_count` preset near wrap (force 0xFFFF) → next frame gives 0x0000.

Source files
------------

// File: rtl/bme280_pkg.sv
// BME280 register map, soft-reset key and sequencer state encoding.
// Shared by the poller FSM and its transaction issuer.
package bme280_pkg;

    localparam logic [7:0] REG_ID         = 8'hD0;
    localparam logic [7:0] REG_RESET      = 8'hE0;
    localparam logic [7:0] REG_CTRL_HUM   = 8'hF2;
    localparam logic [7:0] REG_CTRL_MEAS  = 8'hF4;
    localparam logic [7:0] REG_CONFIG     = 8'hF5;
    localparam logic [7:0] REG_PRESS_MSB  = 8'hF7;
    localparam logic [7:0] REG_PRESS_LSB  = 8'hF8;
    localparam logic [7:0] REG_PRESS_XLSB = 8'hF9;
    localparam logic [7:0] REG_TEMP_MSB   = 8'hFA;
    localparam logic [7:0] REG_TEMP_LSB   = 8'hFB;
    localparam logic [7:0] REG_TEMP_XLSB  = 8'hFC;
    localparam logic [7:0] REG_HUM_MSB    = 8'hFD;
    localparam logic [7:0] REG_HUM_LSB    = 8'hFE;

    localparam logic [7:0] SOFT_RESET_VAL = 8'hB6;
    localparam int         N_CFG          = 3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RST_WR,
        S_RST_DLY,
        S_CFG,
        S_WAIT_PER,
        S_RD,
        S_PUB,
        S_ERR
    } state_t;

    // ctrl_hum only latches on a later ctrl_meas write, so it goes first
    function automatic logic [7:0] cfg_reg(input logic [3:0] idx);
        case (idx)
            4'd0:    return REG_CTRL_HUM;
            4'd1:    return REG_CTRL_MEAS;
            default: return REG_CONFIG;
        endcase
    endfunction

endpackage

// File: rtl/i2c_txn_issuer.sv
// Single-transaction front end for i2c_master: registers the command,
// holds m_en until m_done, and flags NACK or timeout.
module i2c_txn_issuer
    import bme280_pkg::*;
#(
    parameter logic [6:0] SLAVE_ADDRESS = 7'h76,
    parameter int         TIMEOUT       = 65535
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_start,
    input  logic       i_rw,
    input  logic [7:0] i_reg,
    input  logic [7:0] i_data,
    output logic [6:0] m_slave_address,
    output logic       m_read_write,
    output logic [7:0] m_register_address,
    output logic [7:0] m_data,
    output logic       m_en,
    input  logic       m_done,
    input  logic       m_nack,
    input  logic [7:0] m_rdata,
    output logic       o_ok,
    output logic       o_err,
    output logic [7:0] o_rdata
);

    localparam logic [31:0] TMO_LAST = 32'(TIMEOUT - 1);

    logic [6:0]  r_addr;
    logic        r_rw;
    logic [7:0]  r_reg;
    logic [7:0]  r_data;
    logic        r_en;
    logic [31:0] r_tmo;
    logic        w_expire;

    // a done pulse on the expiry cycle still counts as success
    assign w_expire = r_en & ~m_done & (r_tmo == TMO_LAST);
    assign o_ok     = r_en & m_done & ~m_nack;
    assign o_err    = r_en & ((m_done & m_nack) | w_expire);
    assign o_rdata  = m_rdata;

    assign m_slave_address    = r_addr;
    assign m_read_write       = r_rw;
    assign m_register_address = r_reg;
    assign m_data             = r_data;
    assign m_en               = r_en;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_addr <= '0;
            r_rw   <= 1'b0;
            r_reg  <= '0;
            r_data <= '0;
            r_en   <= 1'b0;
            r_tmo  <= '0;
        end else if (!r_en) begin
            if (i_start) begin
                r_addr <= SLAVE_ADDRESS;
                r_rw   <= i_rw;
                r_reg  <= i_reg;
                r_data <= i_data;
                r_en   <= 1'b1;
                r_tmo  <= '0;
            end
        end else if (m_done || w_expire) begin
            r_en <= 1'b0;
        end else begin
            r_tmo <= r_tmo + 32'd1;
        end
    end

endmodule

// File: rtl/bme280_poller.sv
// BME280 sequencer: soft reset, config writes, then periodic burst reads
// published as coherent frames.
module bme280_poller
    import bme280_pkg::*;
#(
    parameter logic [6:0] SLAVE_ADDRESS = 7'h76,
    parameter int         N_READ        = 8,
    parameter logic [7:0] BASE_REG      = REG_PRESS_MSB,
    parameter logic [7:0] CTRL_HUM      = 8'h01,
    parameter logic [7:0] CTRL_MEAS     = 8'h27,
    parameter logic [7:0] CONFIG        = 8'h00,
    parameter int         RST_WAIT      = 20000,
    parameter int         POLL_PERIOD   = 1000000,
    parameter int         TIMEOUT       = 65535
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    output logic [6:0]            m_slave_address,
    output logic                  m_read_write,
    output logic [7:0]            m_register_address,
    output logic [7:0]            m_data,
    output logic                  m_en,
    input  logic                  m_done,
    input  logic                  m_nack,
    input  logic [7:0]            m_rdata,
    output logic [8*N_READ-1:0]   frame_data,
    output logic                  frame_valid,
    output logic [15:0]           frame_count,
    output logic                  busy,
    output logic                  err
);

    localparam logic [31:0] RST_LAST = 32'(RST_WAIT - 1);
    localparam logic [31:0] PER_LAST = 32'(POLL_PERIOD - 1);
    localparam logic [3:0]  CFG_LAST = 4'(N_CFG - 1);
    localparam logic [3:0]  RD_LAST  = 4'(N_READ - 1);

    state_t              r_state, w_state_n;
    logic [3:0]          r_idx, w_idx_n;
    logic [31:0]         r_cnt;
    logic                w_cnt_clr;
    logic                w_txn;
    logic                w_start;
    logic                w_rw;
    logic [7:0]          w_reg;
    logic [7:0]          w_data;
    logic                w_ok;
    logic                w_err;
    logic [7:0]          w_rdata;
    logic [8*N_READ-1:0] r_shadow;
    logic [8*N_READ-1:0] r_frame_data;
    logic                r_frame_valid;
    logic [15:0]         r_frame_count;
    logic                r_err;

    i2c_txn_issuer #(
        .SLAVE_ADDRESS (SLAVE_ADDRESS),
        .TIMEOUT       (TIMEOUT)
    ) u_issuer (
        .clk                (clk),
        .rst                (rst),
        .i_start            (w_start),
        .i_rw               (w_rw),
        .i_reg              (w_reg),
        .i_data             (w_data),
        .m_slave_address    (m_slave_address),
        .m_read_write       (m_read_write),
        .m_register_address (m_register_address),
        .m_data             (m_data),
        .m_en               (m_en),
        .m_done             (m_done),
        .m_nack             (m_nack),
        .m_rdata            (m_rdata),
        .o_ok               (w_ok),
        .o_err              (w_err),
        .o_rdata            (w_rdata)
    );

    always_comb begin
        w_state_n = r_state;
        w_idx_n   = r_idx;
        w_cnt_clr = 1'b0;
        w_txn     = 1'b0;
        w_start   = 1'b0;
        w_rw      = 1'b0;
        w_reg     = 8'h00;
        w_data    = 8'h00;
        unique case (r_state)
            S_IDLE: begin
                if (en) begin
                    w_state_n = S_RST_WR;
                    w_idx_n   = '0;
                end
            end
            S_RST_WR: begin
                w_txn  = 1'b1;
                w_reg  = REG_RESET;
                w_data = SOFT_RESET_VAL;
            end
            S_RST_DLY: begin
                if (!en) begin
                    w_state_n = S_IDLE;
                end else if (r_cnt >= RST_LAST) begin
                    w_state_n = S_CFG;
                    w_idx_n   = '0;
                end
            end
            S_CFG: begin
                w_txn  = 1'b1;
                w_reg  = cfg_reg(r_idx);
                w_data = (r_idx == 4'd0) ? CTRL_HUM :
                         (r_idx == 4'd1) ? CTRL_MEAS : CONFIG;
            end
            S_WAIT_PER: begin
                if (!en) begin
                    w_state_n = S_IDLE;
                end else if (r_cnt >= PER_LAST) begin
                    w_state_n = S_RD;
                    w_idx_n   = '0;
                    w_cnt_clr = 1'b1;
                end
            end
            S_RD: begin
                w_txn = 1'b1;
                w_rw  = 1'b1;
                w_reg = BASE_REG + {4'h0, r_idx};
            end
            S_PUB: w_state_n = S_WAIT_PER;
            S_ERR: begin
                if (!en) w_state_n = S_IDLE;
            end
            default: w_state_n = S_IDLE;
        endcase
        // a bus transaction in flight is never abandoned; en is honoured after it
        if (w_txn) begin
            if (w_err) begin
                w_state_n = S_ERR;
            end else if (w_ok && !en) begin
                w_state_n = S_IDLE;
            end else if (w_ok) begin
                unique case (r_state)
                    S_RST_WR: begin
                        w_state_n = S_RST_DLY;
                        w_cnt_clr = 1'b1;
                    end
                    S_CFG: begin
                        if (r_idx == CFG_LAST) begin
                            w_state_n = S_RD;
                            w_idx_n   = '0;
                            w_cnt_clr = 1'b1;
                        end else begin
                            w_idx_n = r_idx + 4'd1;
                        end
                    end
                    S_RD: begin
                        if (r_idx == RD_LAST) w_state_n = S_PUB;
                        else w_idx_n = r_idx + 4'd1;
                    end
                    default: w_state_n = r_state;
                endcase
            end else if (!m_en) begin
                if (!en) w_state_n = S_IDLE;
                else w_start = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_n;
            r_idx   <= w_idx_n;
            if (w_cnt_clr) r_cnt <= '0;
            else if (r_cnt != '1) r_cnt <= r_cnt + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_shadow      <= '0;
            r_frame_data  <= '0;
            r_frame_valid <= 1'b0;
            r_frame_count <= '0;
            r_err         <= 1'b0;
        end else begin
            r_frame_valid <= (r_state == S_PUB);
            if (r_state == S_PUB) begin
                r_frame_data  <= r_shadow;
                r_frame_count <= r_frame_count + 16'd1;
            end
            if (w_ok && r_state == S_RD) begin
                for (int i = 0; i < N_READ; i++) begin
                    if (r_idx == 4'(i)) r_shadow[8*i +: 8] <= w_rdata;
                end
            end
            if (w_state_n == S_IDLE) r_err <= 1'b0;
            else if (w_err) r_err <= 1'b1;
        end
    end

    assign frame_data  = r_frame_data;
    assign frame_valid = r_frame_valid;
    assign frame_count = r_frame_count;
    assign busy        = (r_state != S_IDLE);
    assign err         = r_err;

endmodule
